// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//   UART receiver. Oversamples the serial line by a runtime prescale,
//   majority-votes three samples around the middle of each bit, and checks
//   the optional parity bit and the stop bit. The recovered word is presented
//   with a single-cycle valid strobe.
//
// Ports
//   clk          UART-domain clock (prescale x baud)
//   reset        asynchronous active-low reset
//   rx_in        serial line, asynchronous to clk, idle high
//   prescale     oversampling ratio: 8, 16 or 32 (anything else acts as 8)
//   par_en       1 = frame carries a parity bit
//   par_type     0 = even parity, 1 = odd parity
//   p_data       last good received word (holds between frames)
//   data_valid   one-cycle pulse when p_data is updated
//   parity_error one-cycle pulse on parity mismatch
//   stop_error   one-cycle pulse when the stop bit votes 0
//   busy         high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_core #(
  parameter int data_width  = 8,
  parameter int presc_width = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_in,
  input  logic [presc_width-1:0] prescale,
  input  logic                   par_en,
  input  logic                   par_type,
  output logic [data_width-1:0]  p_data,
  output logic                   data_valid,
  output logic                   parity_error,
  output logic                   stop_error,
  output logic                   busy
);

  localparam int bcw = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [bcw-1:0] last_bit = bcw'(data_width - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_CHECK  = 3'd5
  } state_t;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  function automatic logic parity_bit(input logic [data_width-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  state_t                  state_r, state_nxt_s;
  logic [1:0]              sync_r;
  logic                    rx_s;
  logic [presc_width-1:0]  presc_r;
  logic                    par_en_r, par_type_r;
  logic [presc_width-1:0]  edge_cnt_r;
  logic [bcw-1:0]          bit_cnt_r;
  logic [2:0]              samp_r;
  logic [data_width-1:0]   shift_r;
  logic                    par_fail_r, stop_fail_r;

  logic [presc_width-1:0]  half_s;
  logic                    wrap_s, vote_pt_s, vote_s, presc_ok_s, cnt_clr_s;

  assign rx_s       = sync_r[1];
  assign half_s     = presc_r >> 1;
  assign wrap_s     = (edge_cnt_r == presc_r - presc_width'(1));
  assign vote_pt_s  = (edge_cnt_r == half_s + presc_width'(2));
  assign vote_s     = majority3(samp_r);
  assign presc_ok_s = (prescale == presc_width'(8)) || (prescale == presc_width'(16)) ||
                      (prescale == presc_width'(32));

  // Two-flop synchroniser for the asynchronous serial line, reset to idle-high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx_in};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. STOP leaves at the vote point rather than the bit end so
  // a start bit directly after the stop bit is seen from IDLE.
  always_comb begin
    state_nxt_s = state_r;
    cnt_clr_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        cnt_clr_s = 1'b1;
        if (!rx_s) state_nxt_s = S_START;
        else       state_nxt_s = S_IDLE;
      end
      S_START: begin
        if (vote_pt_s && vote_s) state_nxt_s = S_IDLE;   // glitch, not a start bit
        else if (wrap_s)         state_nxt_s = S_DATA;
        else                     state_nxt_s = S_START;
      end
      S_DATA: begin
        if (wrap_s && (bit_cnt_r == last_bit)) state_nxt_s = par_en_r ? S_PARITY : S_STOP;
        else                                   state_nxt_s = S_DATA;
      end
      S_PARITY: begin
        if (wrap_s) state_nxt_s = S_STOP;
        else        state_nxt_s = S_PARITY;
      end
      S_STOP: begin
        if (vote_pt_s) state_nxt_s = S_CHECK;
        else           state_nxt_s = S_STOP;
      end
      S_CHECK: begin
        cnt_clr_s   = 1'b1;
        state_nxt_s = S_IDLE;
      end
      default: begin
        cnt_clr_s   = 1'b1;
        state_nxt_s = S_IDLE;
      end
    endcase
    if ((state_nxt_s == S_IDLE) || (state_nxt_s == S_CHECK) || wrap_s) cnt_clr_s = 1'b1;
    else                                                              cnt_clr_s = cnt_clr_s;
  end

  // Bit-phase and bit-index counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_cnt_r <= '0;
      bit_cnt_r  <= '0;
    end else begin
      edge_cnt_r <= cnt_clr_s ? '0 : edge_cnt_r + presc_width'(1);
      if (state_r != S_DATA)  bit_cnt_r <= '0;
      else if (wrap_s)        bit_cnt_r <= (bit_cnt_r == last_bit) ? '0 : bit_cnt_r + bcw'(1);
      else                    bit_cnt_r <= bit_cnt_r;
    end
  end

  // Frame configuration, captured only when a start edge is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_r    <= presc_width'(8);
      par_en_r   <= 1'b0;
      par_type_r <= 1'b0;
    end else if ((state_r == S_IDLE) && !rx_s) begin
      presc_r    <= presc_ok_s ? prescale : presc_width'(8);
      par_en_r   <= par_en;
      par_type_r <= par_type;
    end
  end

  // Three samples around mid-bit, shift register and per-frame error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp_r      <= 3'b111;
      shift_r     <= '0;
      par_fail_r  <= 1'b0;
      stop_fail_r <= 1'b0;
    end else begin
      if (edge_cnt_r == half_s - presc_width'(1)) samp_r[0] <= rx_s;
      if (edge_cnt_r == half_s)                   samp_r[1] <= rx_s;
      if (edge_cnt_r == half_s + presc_width'(1)) samp_r[2] <= rx_s;
      if ((state_r == S_DATA) && vote_pt_s) shift_r <= {vote_s, shift_r[data_width-1:1]};
      if (state_r == S_IDLE) begin
        par_fail_r  <= 1'b0;
        stop_fail_r <= 1'b0;
      end else begin
        if ((state_r == S_PARITY) && vote_pt_s)
          par_fail_r <= (vote_s != parity_bit(shift_r, par_type_r));
        if ((state_r == S_STOP) && vote_pt_s)
          stop_fail_r <= ~vote_s;
      end
    end
  end

  // Registered outputs; the frame verdict lands the cycle after CHECK.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_data       <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      data_valid   <= (state_r == S_CHECK) && !par_fail_r && !stop_fail_r;
      parity_error <= (state_r == S_CHECK) && par_fail_r;
      stop_error   <= (state_r == S_CHECK) && stop_fail_r;
      busy         <= (state_nxt_s != S_IDLE);
      if ((state_r == S_CHECK) && !par_fail_r && !stop_fail_r) p_data <= shift_r;
    end
  end

endmodule
